// File: rtl/reorder_buffer_pkg.sv
// Reorder buffer shared sizes and types.
// Entry, writeback and pointer types used by the ROB and its users.
package reorder_buffer_pkg;

   localparam int ROB_LENGTH      = 16;
   localparam int ROB_IDX_W       = 4;
   localparam int ROB_CNT_W       = ROB_IDX_W + 1;
   localparam int INT_DATA_W      = 32;
   localparam int INSTR_MEM_IDX_W = 8;

   typedef logic [ROB_IDX_W-1:0]       rob_idx_t;
   typedef logic [ROB_CNT_W-1:0]       rob_cnt_t;
   typedef logic [INSTR_MEM_IDX_W-1:0] pc_t;

   typedef struct packed {
      logic                  valid;
      logic                  done;
      logic [INT_DATA_W-1:0] result;
      pc_t                   pc;
      logic                  is_branch;
      logic                  pred_taken;
      pc_t                   pred_target;
      logic                  is_load;
      logic                  is_store;
      logic [6:0]            opcode;
      logic [2:0]            funct;
      logic [4:0]            rd;
   } rob_entry_t;

   typedef struct packed {
      rob_idx_t              idx;
      logic [INT_DATA_W-1:0] result;
      logic                  taken;
      pc_t                   target;
   } rob_wb_t;

   // Word-indexed fall-through; wraps at the top of instruction memory.
   function automatic pc_t next_pc(pc_t pc);
      return pc + 1'b1;
   endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Reorder buffer port bundle.
// The core side drives as master; the ROB is the slave.
import reorder_buffer_pkg::*;

interface reorder_buffer_if;

   logic       alloc_valid;
   logic       alloc_ready;
   rob_entry_t alloc_entry;
   rob_idx_t   alloc_idx;

   logic                  wb_valid;
   rob_idx_t              wb_idx;
   logic [INT_DATA_W-1:0] wb_result;
   logic                  wb_taken;
   pc_t                   wb_target;

   logic       commit_valid;
   logic       commit_ready;
   rob_entry_t commit_entry;
   rob_idx_t   commit_idx;

   logic flush;
   pc_t  flush_pc;

   modport master (
      output alloc_valid, alloc_entry,
      output wb_valid, wb_idx, wb_result,
      output wb_taken, wb_target,
      output commit_ready,
      input  alloc_ready, alloc_idx,
      input  commit_valid, commit_entry,
      input  commit_idx, flush, flush_pc
   );

   modport slave (
      input  alloc_valid, alloc_entry,
      input  wb_valid, wb_idx, wb_result,
      input  wb_taken, wb_target,
      input  commit_ready,
      output alloc_ready, alloc_idx,
      output commit_valid, commit_entry,
      output commit_idx, flush, flush_pc
   );

endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order commit of out-of-order results,
// with branch resolution and mispredict flush at commit.
import reorder_buffer_pkg::*;

module reorder_buffer (
   input logic             clk,
   input logic             rst,
   reorder_buffer_if.slave rob
);

   rob_entry_t            entries [ROB_LENGTH];
   logic [ROB_LENGTH-1:0] br_taken;
   pc_t                   br_target [ROB_LENGTH];

   rob_idx_t head;
   rob_idx_t tail;
   rob_cnt_t count;
   logic     flush_q;
   pc_t      flush_pc_q;

   rob_entry_t head_entry;
   rob_entry_t new_entry;
   rob_wb_t    wb;
   logic       alloc_fire;
   logic       commit_fire;
   logic       wb_hit;
   logic       st_taken;
   pc_t        st_target;
   logic       mispredict;
   pc_t        restart_pc;

   assign wb = '{
      idx:    rob.wb_idx,
      result: rob.wb_result,
      taken:  rob.wb_taken,
      target: rob.wb_target
   };

   assign head_entry = entries[head];

   assign rob.alloc_ready  = count != rob_cnt_t'(ROB_LENGTH);
   assign rob.alloc_idx    = tail;
   assign rob.commit_valid = head_entry.valid & head_entry.done;
   assign rob.commit_entry = head_entry;
   assign rob.commit_idx   = head;
   assign rob.flush        = flush_q;
   assign rob.flush_pc     = flush_pc_q;

   assign alloc_fire  = rob.alloc_valid & rob.alloc_ready;
   assign commit_fire = rob.commit_valid & rob.commit_ready;

   // A writeback aimed at the slot being allocated loses to the allocation.
   assign wb_hit = rob.wb_valid & entries[wb.idx].valid
                 & ~(alloc_fire & (wb.idx == tail));

   always_comb begin
      new_entry        = rob.alloc_entry;
      new_entry.valid  = 1'b1;
      new_entry.done   = 1'b0;
      new_entry.result = '0;
   end

   assign st_taken  = br_taken[head];
   assign st_target = br_target[head];

   assign mispredict = commit_fire & head_entry.is_branch
                     & ((st_taken != head_entry.pred_taken)
                       | (st_taken
                         & (st_target != head_entry.pred_target)));

   assign restart_pc = st_taken ? st_target : next_pc(head_entry.pc);

   always_ff @(posedge clk) begin
      if (rst) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         flush_q    <= 1'b0;
         flush_pc_q <= '0;
         for (int i = 0; i < ROB_LENGTH; i++) begin
            entries[i] <= '0;
         end
      end else if (mispredict) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         flush_q    <= 1'b1;
         flush_pc_q <= restart_pc;
         for (int i = 0; i < ROB_LENGTH; i++) begin
            entries[i].valid <= 1'b0;
         end
      end else begin
         flush_q <= 1'b0;
         if (alloc_fire) begin
            entries[tail] <= new_entry;
            tail          <= tail + 1'b1;
         end
         if (wb_hit) begin
            entries[wb.idx].done   <= 1'b1;
            entries[wb.idx].result <= wb.result;
         end
         if (commit_fire) begin
            entries[head].valid <= 1'b0;
            head                <= head + 1'b1;
         end
         case ({alloc_fire, commit_fire})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Resolved branch outcome; only meaningful while the entry is valid.
   always_ff @(posedge clk) begin
      if (!rst && !mispredict && wb_hit
          && entries[wb.idx].is_branch) begin
         br_taken[wb.idx]  <= wb.taken;
         br_target[wb.idx] <= wb.target;
      end
   end

endmodule
